serial_adder: RTL and testbench

//  Bit-serial ripple adder: adds two N-bit operands one bit per clock, LSB first.
//  A single registered carry links the bit cycles.
//  The N-bit sum and the carry-out appear after exactly N run cycles.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_full_adder.sv | 15 +
 rtl/serial_adder.sv | 81 ++++++++
 tb/tb_serial_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the arithmetic core of the serial adder.
module full_adder
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = maj3(x, y, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit per clock, LSB first, single registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = DEFAULT_WIDTH
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rst,
  input  logic         ld,
  input  logic         clk,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] r_cnt;
  logic          r_c;
  logic [N-1:0]  r_opa;
  logic [N-1:0]  r_opb;

  logic          w_first;
  logic          w_last;
  logic          w_run;
  logic [N-1:0]  w_opa_sh;
  logic [N-1:0]  w_opb_sh;
  logic          w_x;
  logic          w_y;
  logic          w_cin;
  logic          w_s;
  logic          w_co;
  logic [N-1:0]  w_mask;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_run   = ld && (r_cnt < CW'(N));

  // Bit 0 comes straight from the ports; later bits from the frozen operands.
  assign w_opa_sh = r_opa >> r_cnt;
  assign w_opb_sh = r_opb >> r_cnt;
  assign w_x      = w_first ? a[0] : w_opa_sh[0];
  assign w_y      = w_first ? b[0] : w_opb_sh[0];
  assign w_cin    = w_first ? 1'b0 : r_c;
  assign w_mask   = N'(1) << r_cnt;

  full_adder u_fa (
    .x   (w_x),
    .y   (w_y),
    .cin (w_cin),
    .s   (w_s),
    .co  (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_opa <= '0;
      r_opb <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (!ld) begin
      // Re-arm: results are kept until the next add overwrites them.
      r_cnt <= '0;
      r_c   <= 1'b0;
    end else if (w_run) begin
      if (w_first) begin
        r_opa <= a;
        r_opb <= b;
      end
      sum   <= (sum & ~w_mask) | (w_s ? w_mask : '0);
      r_c   <= w_co;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        cout <= w_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder (N=8 and N=1 instances).
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       cout;

  logic       rst1;
  logic       ld1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic [0:0] sum1;
  logic       cout1;

  int n_checks;
  int n_fail;
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;

  serial_adder #(.N(8)) dut (
    .a    (a),
    .b    (b),
    .rst  (rst),
    .ld   (ld),
    .clk  (clk),
    .sum  (sum),
    .cout (cout)
  );

  serial_adder #(.N(1)) dut1 (
    .a    (a1),
    .b    (b1),
    .rst  (rst1),
    .ld   (ld1),
    .clk  (clk),
    .sum  (sum1),
    .cout (cout1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $display("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, expv);
    end
  endtask

  task automatic start_add(input logic [7:0] va, input logic [7:0] vb);
    a  = va;
    b  = vb;
    ld = 1'b1;
    exp_q.push_back(9'(va) + 9'(vb));
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_empty_queue"}, 9'h1FF, 9'h000);
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_sum"},  {1'b0, sum},      {1'b0, last_exp[7:0]});
      check({tag, "_cout"}, {8'h00, cout},    {8'h00, last_exp[8]});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; ld = 1'b0; a = 8'h00; b = 8'h00;
    rst1 = 1'b0; ld1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    // 1. async reset takes effect without a clock edge
    #2;
    rst = 1'b1; rst1 = 1'b1; ld = 1'b1; a = 8'h5A; b = 8'hA5;
    #1;
    check("rst_sum",  {1'b0, sum},   9'h000);
    check("rst_cout", {8'h00, cout}, 9'h000);
    repeat (2) tick();
    check("rst_hold_sum",  {1'b0, sum},   9'h000);
    check("rst_hold_cout", {8'h00, cout}, 9'h000);

    // 2. 0xEA + 0xF3, then hold while ld stays high
    rst = 1'b0; rst1 = 1'b0;
    start_add(8'hEA, 8'hF3);
    repeat (8) tick();
    pop_check("add_ea_f3");
    check("add_ea_f3_const", {cout, sum}, 9'h1DD);
    repeat (4) tick();
    check("done_hold", {cout, sum}, last_exp);

    // 3. re-arm and two more adds
    ld = 1'b0;
    tick();
    start_add(8'h12, 8'h34);
    repeat (8) tick();
    pop_check("add_12_34");
    ld = 1'b0;
    tick();
    start_add(8'hFF, 8'h01);
    repeat (8) tick();
    pop_check("add_ff_01");

    // 4. operand changes after bit 0 are ignored
    ld = 1'b0;
    tick();
    start_add(8'h0F, 8'h01);
    tick();
    a = 8'hFF; b = 8'hFF;
    repeat (7) tick();
    pop_check("frozen");

    // 5. async reset mid-add, then full rerun
    ld = 1'b0;
    tick();
    a = 8'hEA; b = 8'hF3; ld = 1'b1;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_sum",  {1'b0, sum},   9'h000);
    check("midrst_cout", {8'h00, cout}, 9'h000);
    #2;
    rst = 1'b0;
    start_add(8'hEA, 8'hF3);
    @(posedge clk);
    #1;
    repeat (7) tick();
    pop_check("rerun");

    // 6. single-bit instance: 1 + 1
    a1 = 1'b1; b1 = 1'b1; ld1 = 1'b1;
    tick();
    check("n1_sum",  {8'h00, sum1},  9'h000);
    check("n1_cout", {8'h00, cout1}, 9'h001);

    check("queue_drained", 9'(exp_q.size()), 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
